// File: rtl/range_vector_decoder_if.sv
// Code/result handshake bundle between a comparison stage, the range decoder
// and the verdict consumer.
interface range_vector_decoder_if;
  logic       code_valid;
  logic       code_ready;
  logic [2:0] code;
  logic [1:0] track;
  logic       result_valid;
  logic       result_ready;
  logic       match;
  logic       err;

  // master: upstream stage plus verdict consumer; slave: the decoder itself
  modport master (
    output code_valid, code, result_ready,
    input  code_ready, track, result_valid, match, err
  );

  modport slave (
    input  code_valid, code, result_ready,
    output code_ready, track, result_valid, match, err
  );
endinterface

// File: rtl/range_vector_decoder.sv
// Folds per-digit 3-bit stage codes (MS digit first) into one in-range verdict
// for a DIGITS*4-bit attribute, publishing the bound-tracking mode upstream.
module range_vector_decoder #(
  parameter int DIGITS    = 4,
  parameter bit INCLUSIVE = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  range_vector_decoder_if.slave  bus
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

  localparam logic [2:0] BOTH   = 3'd0;
  localparam logic [2:0] TRK_UB = 3'd1;
  localparam logic [2:0] TRK_LB = 3'd2;
  localparam logic [2:0] HIT    = 3'd3;
  localparam logic [2:0] MISS   = 3'd4;

  logic [2:0]    state_q, state_d, step_state;
  logic          step_illegal;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          result_valid_q, result_valid_d;
  logic          match_q, match_d;
  logic          err_q, err_d;
  logic          code_ready, code_fire, result_fire;
  logic [1:0]    track;

  // ready_q only gates the very first cycle after reset release
  assign code_ready  = ready_q & ~result_valid_q;
  assign code_fire   = bus.code_valid & code_ready;
  assign result_fire = result_valid_q & bus.result_ready;

  always_comb begin
    step_state   = state_q;
    step_illegal = 1'b0;
    case (state_q)
      BOTH: begin
        case (bus.code)
          3'b111:  step_state = HIT;
          3'b100:  step_state = TRK_UB;
          3'b001:  step_state = TRK_LB;
          3'b010:  step_state = BOTH;
          3'b000:  step_state = MISS;
          default: begin
            step_state   = MISS;
            step_illegal = 1'b1;
          end
        endcase
      end
      TRK_UB: begin
        case (bus.code)
          3'b111, 3'b001: step_state = HIT;
          3'b100, 3'b010: step_state = TRK_UB;
          3'b000:         step_state = MISS;
          default: begin
            step_state   = MISS;
            step_illegal = 1'b1;
          end
        endcase
      end
      TRK_LB: begin
        case (bus.code)
          3'b111, 3'b100: step_state = HIT;
          3'b001, 3'b010: step_state = TRK_LB;
          3'b000:         step_state = MISS;
          default: begin
            step_state   = MISS;
            step_illegal = 1'b1;
          end
        endcase
      end
      default: step_state = state_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    ready_d        = 1'b1;
    result_valid_d = result_valid_q;
    match_d        = match_q;
    err_d          = err_q;
    if (result_fire) begin
      result_valid_d = 1'b0;
      state_d        = BOTH;
      err_d          = 1'b0;
    end else if (code_fire) begin
      state_d = step_state;
      err_d   = err_q | step_illegal;
      // every attribute consumes exactly DIGITS codes, even after an early verdict
      if (cnt_q == LAST_DIGIT) begin
        cnt_d          = '0;
        result_valid_d = 1'b1;
        match_d        = (step_state == HIT) ||
                         ((INCLUSIVE == 1'b1) && (step_state != MISS));
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    case (state_q)
      BOTH:    track = 2'b00;
      TRK_UB:  track = 2'b01;
      TRK_LB:  track = 2'b10;
      default: track = 2'b11;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= BOTH;
      cnt_q          <= '0;
      ready_q        <= 1'b0;
      result_valid_q <= 1'b0;
      match_q        <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      result_valid_q <= result_valid_d;
      match_q        <= match_d;
      err_q          <= err_d;
    end
  end

  assign bus.code_ready   = code_ready;
  assign bus.track        = track;
  assign bus.result_valid = result_valid_q;
  assign bus.match        = match_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_range_vector_decoder.sv
// Bench: plays the upstream stage from a random attribute/bound triple and
// checks both INCLUSIVE variants against arithmetic range comparisons.
module tb_range_vector_decoder;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  range_vector_decoder_if bi ();
  range_vector_decoder_if bx ();
  assign bx.code_valid   = bi.code_valid;
  assign bx.code         = bi.code;
  assign bx.result_ready = bi.result_ready;

  range_vector_decoder #(.DIGITS(DIGITS), .INCLUSIVE(1'b1)) dut_i (
    .clk(clk), .rst(rst), .bus(bi.slave));
  range_vector_decoder #(.DIGITS(DIGITS), .INCLUSIVE(1'b0)) dut_x (
    .clk(clk), .rst(rst), .bus(bx.slave));

  int checks = 0;
  int passed = 0;

  // reference model: attribute, bounds and progress through the current attribute
  logic [W-1:0] a_v, lb_v, ub_v;
  int   ndig = 0;
  bit   m_err = 0, m_pend = 0, m_rdy_en = 0;
  bit   exp_mi = 0, exp_mx = 0;
  bit   dir_mode = 1;
  int   inj_dig = -1;
  logic [2:0] inj_code = 3'b000;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
  endtask

  // bounds still tied to the consumed prefix: 00 both, 01 UB only, 10 LB only, 11 decided
  function automatic logic [1:0] model_track();
    logic [63:0] pa, pl, pu;
    int sh;
    if (m_err) return 2'b11;
    sh = 4 * (DIGITS - ndig);
    pa = 64'(a_v) >> sh;
    pl = 64'(lb_v) >> sh;
    pu = 64'(ub_v) >> sh;
    return {pa != pu, pa != pl};
  endfunction

  task automatic new_attr();
    logic [W-1:0] mask, t;
    int k;
    lb_v = W'($urandom);
    k = $urandom_range(0, DIGITS);
    mask = W'((64'd1 << (4 * k)) - 64'd1);
    ub_v = (lb_v & ~mask) | (W'($urandom) & mask);
    if (ub_v < lb_v) begin t = ub_v; ub_v = lb_v; lb_v = t; end
    k = $urandom_range(0, DIGITS);
    mask = W'((64'd1 << (4 * k)) - 64'd1);
    case ($urandom_range(0, 4))
      0: a_v = lb_v;
      1: a_v = ub_v;
      2: a_v = (lb_v & ~mask) | (W'($urandom) & mask);
      3: a_v = (ub_v & ~mask) | (W'($urandom) & mask);
      default: a_v = W'($urandom);
    endcase
  endtask

  task automatic model_reset();
    ndig = 0; m_err = 0; m_pend = 0; m_rdy_en = 0; exp_mi = 0; exp_mx = 0;
    new_attr();
  endtask

  task automatic model_update();
    logic [1:0] t;
    bit acc;
    t = model_track();
    acc = bi.code_valid && m_rdy_en && !m_pend;
    if (m_pend && bi.result_ready) begin
      m_pend = 0; ndig = 0; m_err = 0;
      new_attr();
    end else if (acc) begin
      if (t != 2'b11 && (bi.code == 3'b011 || bi.code == 3'b101 || bi.code == 3'b110))
        m_err = 1;
      ndig++;
      if (ndig == DIGITS) begin
        m_pend = 1;
        exp_mi = !m_err && (lb_v <= a_v) && (a_v <= ub_v);
        exp_mx = !m_err && (lb_v < a_v) && (a_v < ub_v);
      end
    end
    m_rdy_en = 1;
  endtask

  // act as the comparison stage for the next digit, then advance one clock
  task automatic step(input bit cv, input bit rr);
    logic [2:0] c;
    logic [1:0] t;
    logic [3:0] av, lv, uv;
    int d, k;
    t = model_track();
    d = ndig;
    c = 3'($urandom_range(0, 7));
    if (!m_pend && t != 2'b11 && d < DIGITS) begin
      av = a_v[4*(DIGITS-1-d) +: 4];
      lv = (t == 2'b01) ? 4'h0 : lb_v[4*(DIGITS-1-d) +: 4];
      uv = (t == 2'b10) ? 4'hF : ub_v[4*(DIGITS-1-d) +: 4];
      if (av == lv && av == uv) c = 3'b010;
      else if (av == uv)        c = 3'b100;
      else if (av == lv)        c = 3'b001;
      else if (av > lv && av < uv) c = 3'b111;
      else                      c = 3'b000;
      if (dir_mode) begin
        if (inj_dig == d) c = inj_code;
      end else if ($urandom_range(0, 15) == 0) begin
        k = $urandom_range(0, 2);
        c = (k == 0) ? 3'b011 : ((k == 1) ? 3'b101 : 3'b110);
      end
    end
    bi.code_valid   = cv;
    bi.code         = c;
    bi.result_ready = rr;
    @(posedge clk);
    #1;
    model_update();
  endtask

  always @(negedge clk) begin
    chk("code_ready_i", bi.code_ready, m_rdy_en && !m_pend);
    chk("code_ready_x", bx.code_ready, m_rdy_en && !m_pend);
    chk("result_valid_i", bi.result_valid, m_pend);
    chk("result_valid_x", bx.result_valid, m_pend);
    chk("track_i", bi.track, model_track());
    chk("track_x", bx.track, model_track());
    chk("err_i", bi.err, m_err);
    chk("err_x", bx.err, m_err);
    if (m_pend) begin
      chk("match_i", bi.match, exp_mi);
      chk("match_x", bx.match, exp_mx);
    end else if (!m_rdy_en) begin
      chk("match_rst_i", bi.match, 1'b0);
      chk("match_rst_x", bx.match, 1'b0);
    end
  end

  task automatic set_attr(input logic [W-1:0] a, input logic [W-1:0] lb, input logic [W-1:0] ub,
                          input int injd, input logic [2:0] injc);
    a_v = a; lb_v = lb; ub_v = ub; inj_dig = injd; inj_code = injc;
  endtask

  task automatic run_attr(input logic [W-1:0] a, input logic [W-1:0] lb, input logic [W-1:0] ub,
                          input int injd, input logic [2:0] injc, input int stall,
                          input bit li, input bit lx, input bit le);
    int guard;
    set_attr(a, lb, ub, injd, injc);
    guard = 0;
    while (!m_pend && guard < 50) begin
      step(1'b1, 1'b0);
      guard++;
    end
    if (!m_pend) chk("dir_timeout", 4'd0, 4'd1);
    for (int s = 0; s < stall; s++) begin
      step(s[0], 1'b0);
      chk("hold_ready", bi.code_ready, 1'b0);
      chk("hold_match_i", bi.match, li);
      chk("hold_err_i", bi.err, le);
    end
    chk("dir_match_i", bi.match, li);
    chk("dir_match_x", bx.match, lx);
    chk("dir_err_i", bi.err, le);
    chk("dir_err_x", bx.err, le);
    $display("attr a=%h lb=%h ub=%h match_i=%0b match_x=%0b err=%0b",
             a, lb, ub, bi.match, bx.match, bi.err);
    step(1'b1, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
  endtask

  initial begin
    int guard;
    rst = 1'b0;
    bi.code_valid = 1'b0;
    bi.code = 3'b000;
    bi.result_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("ready_before_first_clk", bi.code_ready, 1'b0);
    step(1'b0, 1'b0);
    chk("ready_after_first_clk", bi.code_ready, 1'b1);

    run_attr(16'h2abc, 16'h1000, 16'h3000, -1, 3'b000, 0, 1'b1, 1'b1, 1'b0);
    run_attr(16'h5000, 16'h3000, 16'h5200, -1, 3'b000, 5, 1'b1, 1'b1, 1'b0);
    run_attr(16'h5555, 16'h1234, 16'h5555, -1, 3'b000, 0, 1'b1, 1'b0, 1'b0);
    run_attr(16'h2300, 16'h2500, 16'h9000, -1, 3'b000, 0, 1'b0, 1'b0, 1'b0);
    run_attr(16'h4444, 16'h4000, 16'h4fff,  1, 3'b101, 0, 1'b0, 1'b0, 1'b1);
    run_attr(16'h2abc, 16'h1000, 16'h3000, -1, 3'b000, 0, 1'b1, 1'b1, 1'b0);
    run_attr(16'h1234, 16'h1234, 16'h5678, -1, 3'b000, 0, 1'b1, 1'b0, 1'b0);
    run_attr(16'h7777, 16'h7777, 16'h7777, -1, 3'b000, 0, 1'b1, 1'b0, 1'b0);

    // reset in the middle of an attribute
    set_attr(16'h4444, 16'h4000, 16'h4fff, 1, 3'b110);
    guard = 0;
    while (ndig < 2 && guard < 20) begin
      step(1'b1, 1'b0);
      guard++;
    end
    if (ndig < 2) chk("mid_reset_timeout", 4'd0, 4'd1);
    rst = 1'b0;
    model_reset();
    #1;
    chk("rst_code_ready", bi.code_ready, 1'b0);
    chk("rst_result_valid", bi.result_valid, 1'b0);
    chk("rst_match", bi.match, 1'b0);
    chk("rst_err", bi.err, 1'b0);
    chk("rst_track", bi.track, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b0);
    run_attr(16'h2abc, 16'h1000, 16'h3000, -1, 3'b000, 0, 1'b1, 1'b1, 1'b0);

    dir_mode = 0;
    inj_dig = -1;
    for (int s = 0; s < 5000; s++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
